// File: rtl/taiga_types.sv
// Shared types for the dual-core snoop invalidation arbiter.
package taiga_types;

  localparam int SNOOP_SRC_W  = 1;
  localparam int SNOOP_LINE_W = 28;

  typedef enum logic {SNP_IDLE, SNP_ISSUE} snoop_state_t;

  typedef struct packed {
    logic [SNOOP_LINE_W-1:0] line;
  } snoop_entry_t;

endpackage

// File: rtl/snoop_inv_arbiter_fifo.sv
// Per-source request queue; exposes head and newest entries so the top can coalesce.
module snoop_req_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [W-1:0]               newest_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data   = mem_q[rd_ptr_q];
  assign newest_data = mem_q[wr_ptr_q - PTR_W'(1)];
  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);

endmodule

// File: rtl/snoop_inv_arbiter.sv
// Round-robin sequencer of dcache write-invalidations onto a shared snoop bus;
// each source's invalidation is presented to the opposite core and awaits its ack.
module snoop_inv_arbiter
  import taiga_types::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_OFS_W  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  output logic [1:0]             req_ready,
  output logic [1:0]             snp_valid,
  output logic [ADDR_W-1:0]      snp_addr,
  input  logic [1:0]             snp_ack,
  output logic [1:0]             pending,
  output logic                   timeout_err
);

  localparam int LINE_W    = ADDR_W - LINE_OFS_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [LINE_W-1:0] req_line    [2];
  logic [LINE_W-1:0] head_line   [2];
  logic [LINE_W-1:0] newest_line [2];
  logic [CNT_W-1:0]  fifo_count  [2];
  logic [1:0]        fifo_full, fifo_empty;
  logic [1:0]        push, pop, coal_hit, heads;

  snoop_state_t            state_q, state_d;
  logic [SNOOP_SRC_W-1:0]  src_q, src_d;
  logic [SNOOP_SRC_W-1:0]  last_grant_q, last_grant_d;
  logic [SNOOP_SRC_W-1:0]  grant_src;
  logic [LINE_W-1:0]       issue_line_q, issue_line_d;
  logic [TMO_CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    ack_seen, drop, done, grant;
  logic                    unused_ofs;

  // Offset bits never reach the queues; only the line identity matters.
  assign unused_ofs = ^{req_addr[0][LINE_OFS_W-1:0], req_addr[1][LINE_OFS_W-1:0]};

  always_comb begin
    for (int i = 0; i < 2; i++) req_line[i] = req_addr[i][ADDR_W-1:LINE_OFS_W];
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    snoop_req_fifo #(
      .W     (LINE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push[g]),
      .push_data   (req_line[g]),
      .pop         (pop[g]),
      .head_data   (head_line[g]),
      .newest_data (newest_line[g]),
      .count       (fifo_count[g]),
      .full        (fifo_full[g]),
      .empty       (fifo_empty[g])
    );
  end

  // A single queued entry leaving this cycle cannot absorb a repeat of itself.
  always_comb begin
    coal_hit = '0;
    for (int i = 0; i < 2; i++) begin
      coal_hit[i] = (fifo_count[i] != '0) && (req_line[i] == newest_line[i]) &&
                    !((fifo_count[i] == CNT_ONE) && pop[i]);
    end
    req_ready = ~fifo_full | coal_hit;
    push      = req_valid & req_ready & ~coal_hit;
  end

  always_comb begin
    heads     = ~fifo_empty;
    grant_src = (&heads) ? ~last_grant_q : heads[1];
    ack_seen  = (state_q == SNP_ISSUE) && snp_ack[~src_q];
    drop      = (ACK_TIMEOUT != 0) && (state_q == SNP_ISSUE) && !ack_seen &&
                (tmo_cnt_q == TMO_LAST);
    done      = ack_seen || drop;
    grant     = (|heads) && ((state_q == SNP_IDLE) || done);

    state_d       = state_q;
    src_d         = src_q;
    last_grant_d  = last_grant_q;
    issue_line_d  = issue_line_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q | drop;
    pop           = '0;

    if (grant) begin
      pop[grant_src] = 1'b1;
      src_d          = grant_src;
      last_grant_d   = grant_src;
      issue_line_d   = head_line[grant_src];
      tmo_cnt_d      = '0;
      state_d        = SNP_ISSUE;
    end else if (done) begin
      state_d = SNP_IDLE;
    end else if (state_q == SNP_ISSUE) begin
      tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SNP_IDLE;
      src_q         <= '0;
      last_grant_q  <= 1'b1;
      issue_line_q  <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      last_grant_q  <= last_grant_d;
      issue_line_q  <= issue_line_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    snp_valid = '0;
    snp_addr  = '0;
    if (state_q == SNP_ISSUE) begin
      snp_valid[~src_q] = 1'b1;
      snp_addr          = {issue_line_q, {LINE_OFS_W{1'b0}}};
    end
    for (int i = 0; i < 2; i++) begin
      pending[i] = (fifo_count[i] != '0) ||
                   ((state_q == SNP_ISSUE) && (src_q == SNOOP_SRC_W'(i)));
    end
  end

  assign timeout_err = timeout_err_q;

endmodule
